wb_line_mem_slave: RTL
======================

// Module: wb_line_mem_slave
// PURPOSE
// - Wishbone slave backing store answering the datapath's ifetch and memory masters.
// - Holds 128-bit lines; applies a fixed, parameterised wait-state latency, then pulses ACK.
// - One instance per master port; stands in for L2/DRAM during pipeline bring-up.
// PARAMETERS
// - LINES    256  number of 128-bit lines stored; power of two, <= 4096
// - LATENCY  3    cycles from request capture to ACK; >= 1
// PORTS
// - clk    in   1    clock; all state on rising edge
// - rst    in   1    asynchronous, active-high reset
// - CYC    in   1    bus cycle valid
// - STB    in   1    strobe; request when CYC & STB
// - WE     in   1    1 = write, 0 = read
// - ADR    in   12   line address (byte address [15:4])
// - SEL    in   16   byte enables; SEL[i] covers DAT_M[8i+7:8i]
// - DAT_M  in   128  write data
// - DAT_S  out  128  read data; valid only while ACK = 1
// - ACK    out  1    single-cycle response strobe
// - ERR    out  1    only with WB_ADDR_CHECK_EN; tied 0 otherwise
// BEHAVIOUR
// - Reset (async, rst = 1): state IDLE, counter 0, ACK = 0, ERR = 0, DAT_S = 0.
//   Line storage is not cleared. Reset mid-transaction drops the request: no write, no ACK.
// - FSM states: IDLE, WAIT, RESP.
// - IDLE & CYC & STB: capture ADR/WE/SEL/DAT_M (this is cycle 0).
//   Next state is RESP if LATENCY == 1, else WAIT with cnt = LATENCY-2.
// - WAIT: decrement cnt. At cnt == 0, go to RESP.
//   Captured fields are used; bus changes to ADR/WE/SEL/DAT_M are ignored.
// - WAIT & !(CYC & STB): abort to IDLE. No write, no ACK.
// - RESP (cycle LATENCY): ACK = 1 for exactly one cycle.
//   - Read: DAT_S = line[idx].
//   - Write: line bytes with SEL[i] = 1 take DAT_M bytes; other bytes are kept.
//     DAT_S = post-write line.
//   - Next state is always IDLE, even if STB is still high.
// - RESP does not check CYC/STB; a response already in RESP always completes.
// - Throughput: with STB held high (ifetch ties STB = CYC = 1), a new request is
//   captured one cycle after ACK. Sustained period is LATENCY+1 cycles.
// - idx = ADR[log2(LINES)-1:0]; upper ADR bits are ignored (aliasing).
// - SEL = 0 write: ACK is issued, storage is unchanged.
// - Outside RESP: ACK = 0, DAT_S = 0.
// CONFIGURATION
// - WB_ADDR_CHECK_EN defined: in RESP, if ADR >= LINES, assert ERR (not ACK) for one cycle.
//   No write is performed; DAT_S = 0. In-range requests behave as above.
// - WB_ADDR_CHECK_EN undefined: ERR is held 0; out-of-range addresses alias via idx.
// TESTING
// - Reset: assert rst mid-WAIT -> ACK = 0, DAT_S = 0 immediately.
//   Release rst, hold STB = 0 -> ACK stays 0.
// - Write/read: write ADR = 0x005, SEL = 0xFFFF, DAT_M = 0x0123..CDEF. ACK exactly 3 cycles
//   after capture. Read ADR = 0x005 -> DAT_S = 0x0123..CDEF.
// - Partial write: SEL = 0x0003, DAT_M[15:0] = 0xBEEF on line 0x005 -> read returns the
//   old line with only [15:0] = 0xBEEF.
// - Back-to-back: hold CYC = STB = 1, WE = 0, ADR = 0x010 ->
//   ACK pulses on cycles 3, 7, 11 (period 4).
// - Abort: drop STB at cycle 1 of a write to 0x020 -> no ACK; later read of 0x020 returns
//   prior contents. LATENCY = 1 build: ACK on cycle 1.
// - WB_ADDR_CHECK_EN with LINES = 256: write ADR = 0x100 -> ERR = 1 for 1 cycle, ACK = 0,
//   line 0x000 unchanged. Without the macro: the same write updates line 0x000 with ACK.

Source files
------------

// File: rtl/wb_line_mem_slave.sv
// Wishbone slave holding 128-bit lines, answering after a fixed wait-state latency.
// Optional: define WB_ADDR_CHECK_EN to answer out-of-range line addresses with ERR.
module wb_line_mem_slave #(
    parameter int LINES   = 256,
    parameter int LATENCY = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         CYC,
    input  logic         STB,
    input  logic         WE,
    input  logic [11:0]  ADR,
    input  logic [15:0]  SEL,
    input  logic [127:0] DAT_M,
    output logic [127:0] DAT_S,
    output logic         ACK,
    output logic         ERR
);
    localparam int IW = $clog2(LINES);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_req;
    logic            w_cap;

    logic [11:0]     r_adr;
    logic            r_we;
    logic [15:0]     r_sel;
    logic [127:0]    r_dat;

    logic [127:0]    r_mem [LINES];

    logic [IW-1:0]   w_idx;
    logic [127:0]    w_line;
    logic [127:0]    w_merged;
    logic            w_resp;
    logic            w_oor;

    assign w_req  = CYC & STB;
    assign w_resp = (r_state == S_RESP);
    assign w_idx  = r_adr[IW-1:0];
    assign w_line = r_mem[w_idx];

`ifdef WB_ADDR_CHECK_EN
    assign w_oor = ({1'b0, r_adr} >= 13'(LINES));
`else
    // Upper address bits alias onto the stored lines.
    logic w_unused_adr;
    assign w_unused_adr = ^r_adr;
    assign w_oor        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cap       = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr <= '0;
            r_we  <= 1'b0;
            r_sel <= '0;
            r_dat <= '0;
        end else if (w_cap) begin
            r_adr <= ADR;
            r_we  <= WE;
            r_sel <= SEL;
            r_dat <= DAT_M;
        end
    end

    always_comb begin
        w_merged = w_line;
        for (int i = 0; i < 16; i++) begin
            if (r_sel[i]) begin
                w_merged[8*i +: 8] = r_dat[8*i +: 8];
            end
        end
    end

    // Storage has no reset; a reset forces IDLE, which blocks the write.
    always_ff @(posedge clk) begin
        if (w_resp && r_we && !w_oor) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign ACK   = w_resp & ~w_oor;
    assign ERR   = w_resp & w_oor;
    assign DAT_S = ACK ? (r_we ? w_merged : w_line) : '0;

endmodule
